// File: rtl/crc_sabitler_pkg.sv
// -----------------------------------------------------------------------------
// crc_sabitler_pkg
// Shared constants for the crc_motoru CRC engine:
//   - durum_t : FSM state encoding (BOSTA idle, BEKLE frame open,
//               ISLE processing bytes, SONUC finalise)
//   - legal CRC widths (16, 32) and legal beat widths in bytes (1, 2, 4),
//     with helper predicates to test a parameter value against them
//   - bayt_ters : bit reversal of one byte (reflected-input CRC variants)
// -----------------------------------------------------------------------------
package crc_sabitler_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        ISLE  = 2'd2,
        SONUC = 2'd3
    } durum_t;

    localparam int unsigned CRC_W_16 = 16;
    localparam int unsigned CRC_W_32 = 32;

    localparam int unsigned BYTES_1 = 1;
    localparam int unsigned BYTES_2 = 2;
    localparam int unsigned BYTES_4 = 4;

    function automatic bit crc_w_gecerli(input int unsigned w);
        return (w == CRC_W_16) || (w == CRC_W_32);
    endfunction

    function automatic bit bytes_gecerli(input int unsigned b);
        return (b == BYTES_1) || (b == BYTES_2) || (b == BYTES_4);
    endfunction

    function automatic logic [7:0] bayt_ters(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_motoru_if.sv
// -----------------------------------------------------------------------------
// crc_motoru_if
// Beat/handshake bundle of the crc_motoru CRC engine.
//   basla_i          : abort any frame, load INIT, open a new frame
//   gecerli_i        : input beat valid
//   hazir_o          : engine accepts a beat this cycle
//   veri_i           : beat data, byte 0 in [7:0]
//   bayt_gecerli_i   : per-byte enable
//   son_i            : beat is the last of its frame
//   crc_o            : final CRC of the last completed frame
//   crc_gecerli_o    : one-cycle pulse when crc_o updates
//   mesgul_o         : a frame is open or being processed
//   beklenen_i/hata_o: expected CRC and mismatch flag, only when the macro
//                      CRC_DOGRULA_EN is defined
// Modports: master = frame source (testbench/upstream), slave = crc_motoru.
// -----------------------------------------------------------------------------
interface crc_motoru_if #(
    parameter int unsigned CRC_W = 16,
    parameter int unsigned BYTES = 1
);
    import crc_sabitler_pkg::*;

    logic                 basla_i;
    logic                 gecerli_i;
    logic                 hazir_o;
    logic [8*BYTES-1:0]   veri_i;
    logic [BYTES-1:0]     bayt_gecerli_i;
    logic                 son_i;
    logic [CRC_W-1:0]     crc_o;
    logic                 crc_gecerli_o;
    logic                 mesgul_o;
`ifdef CRC_DOGRULA_EN
    logic [CRC_W-1:0]     beklenen_i;
    logic                 hata_o;

    modport master (
        output basla_i, gecerli_i, veri_i, bayt_gecerli_i, son_i, beklenen_i,
        input  hazir_o, crc_o, crc_gecerli_o, mesgul_o, hata_o
    );

    modport slave (
        input  basla_i, gecerli_i, veri_i, bayt_gecerli_i, son_i, beklenen_i,
        output hazir_o, crc_o, crc_gecerli_o, mesgul_o, hata_o
    );
`else
    modport master (
        output basla_i, gecerli_i, veri_i, bayt_gecerli_i, son_i,
        input  hazir_o, crc_o, crc_gecerli_o, mesgul_o
    );

    modport slave (
        input  basla_i, gecerli_i, veri_i, bayt_gecerli_i, son_i,
        output hazir_o, crc_o, crc_gecerli_o, mesgul_o
    );
`endif

endinterface

// File: rtl/crc_bayt_adim.sv
// -----------------------------------------------------------------------------
// crc_bayt_adim
// Combinational one-byte CRC step, MSB first, computed as eight unrolled
// shift/XOR divisions by POLY (no table):
//   crc_o = (crc_i << 8) ^ f(crc_i[CRC_W-1 -: 8] ^ bayt_i)
// Ports:
//   crc_i  : current CRC register
//   bayt_i : data byte (already bit-reversed by the caller if reflected)
//   crc_o  : register after absorbing the byte
// -----------------------------------------------------------------------------
module crc_bayt_adim #(
    parameter int unsigned      CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       bayt_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] r;

    always_comb begin
        // XOR the byte into the top of the register, then divide 8 times.
        r = crc_i ^ {bayt_i, {(CRC_W-8){1'b0}}};
        for (int b = 0; b < 8; b++) begin
            r = r[CRC_W-1] ? ((r << 1) ^ POLY) : (r << 1);
        end
        crc_o = r;
    end

endmodule

// File: rtl/crc_motoru.sv
// -----------------------------------------------------------------------------
// crc_motoru
// Frame-oriented CRC engine. Beats of up to BYTES bytes are accepted through
// a valid/ready handshake, their enabled bytes are absorbed one per cycle in
// ascending byte order, and the closing beat produces a registered CRC with a
// one-cycle valid pulse.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : crc_motoru_if.slave (basla/gecerli/hazir/veri/bayt_gecerli/son
//           inputs and handshake, crc/crc_gecerli/mesgul outputs)
// Parameters: CRC_W (16/32), POLY, INIT, XOR_OUT, REFLECT, BYTES (1/2/4).
// Optional feature: define CRC_DOGRULA_EN to add beklenen_i/hata_o, a
// compare of the final CRC against an expected value, held with crc_o.
// -----------------------------------------------------------------------------
module crc_motoru
    import crc_sabitler_pkg::*;
#(
    parameter int unsigned      CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b0,
    parameter int unsigned      BYTES   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    crc_motoru_if.slave bus
);

    durum_t             durum_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_cikis_q;
    logic               crc_gecerli_q;
    logic               hazir_q;
    logic               mesgul_q;

    logic [8*BYTES-1:0] veri_p0;
    logic [BYTES-1:0]   maske_p0;
    logic               son_p0;

    logic [7:0]         bayt_sec;
    logic [7:0]         adim_girdi;
    logic [BYTES-1:0]   kalan;
    logic               bulundu;
    logic [CRC_W-1:0]   adim_cikis;
    logic [CRC_W-1:0]   crc_sonraki;
    logic [CRC_W-1:0]   son_deger;
    logic               aktarim;

    function automatic logic [CRC_W-1:0] bit_ters(input logic [CRC_W-1:0] d);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = d[CRC_W-1-i];
        end
        return r;
    endfunction

    function automatic logic en_fazla_bir(input logic [BYTES-1:0] m);
        return (m & (m - BYTES'(1))) == '0;
    endfunction

    assign aktarim = bus.gecerli_i && hazir_q;

    // Pick the lowest enabled byte still pending; disabled bytes cost nothing.
    always_comb begin
        bayt_sec = 8'h00;
        kalan    = maske_p0;
        bulundu  = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (maske_p0[i] && !bulundu) begin
                bayt_sec = veri_p0[8*i +: 8];
                kalan[i] = 1'b0;
                bulundu  = 1'b1;
            end
        end
    end

    assign adim_girdi = REFLECT ? bayt_ters(bayt_sec) : bayt_sec;

    crc_bayt_adim #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_adim (
        .crc_i  (crc_q),
        .bayt_i (adim_girdi),
        .crc_o  (adim_cikis)
    );

    assign crc_sonraki = bulundu ? adim_cikis : crc_q;
    assign son_deger   = (REFLECT ? bit_ters(crc_sonraki) : crc_sonraki) ^ XOR_OUT;

    // The last byte of a closing beat is absorbed during SONUC itself, so a
    // beat with n enabled bytes holds hazir_o low for n cycles (at least one)
    // whether or not it closes the frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q       <= BOSTA;
            crc_q         <= INIT;
            crc_cikis_q   <= '0;
            crc_gecerli_q <= 1'b0;
            hazir_q       <= 1'b1;
            mesgul_q      <= 1'b0;
        end else begin
            crc_gecerli_q <= 1'b0;
            if (bus.basla_i && !aktarim) begin
                durum_q  <= BEKLE;
                crc_q    <= INIT;
                hazir_q  <= 1'b1;
                mesgul_q <= 1'b1;
            end else begin
                case (durum_q)
                    BOSTA, BEKLE: begin
                        if (aktarim) begin
                            veri_p0  <= bus.veri_i;
                            maske_p0 <= bus.bayt_gecerli_i;
                            son_p0   <= bus.son_i;
                            if (durum_q == BOSTA || bus.basla_i) begin
                                crc_q <= INIT;
                            end
                            hazir_q  <= 1'b0;
                            mesgul_q <= 1'b1;
                            durum_q  <= (bus.son_i && en_fazla_bir(bus.bayt_gecerli_i))
                                        ? SONUC : ISLE;
                        end
                    end
                    ISLE: begin
                        crc_q    <= crc_sonraki;
                        maske_p0 <= kalan;
                        if (son_p0 ? en_fazla_bir(kalan) : (kalan == '0)) begin
                            durum_q <= son_p0 ? SONUC : BEKLE;
                            hazir_q <= !son_p0;
                        end
                    end
                    SONUC: begin
                        crc_cikis_q   <= son_deger;
                        crc_gecerli_q <= 1'b1;
                        crc_q         <= INIT;
                        durum_q       <= BOSTA;
                        hazir_q       <= 1'b1;
                        mesgul_q      <= 1'b0;
                    end
                    default: begin
                        durum_q  <= BOSTA;
                        hazir_q  <= 1'b1;
                        mesgul_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CRC_DOGRULA_EN
    logic hata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hata_q <= 1'b0;
        end else if (durum_q == SONUC && !bus.basla_i) begin
            hata_q <= (son_deger != bus.beklenen_i);
        end
    end

    assign bus.hata_o = hata_q;
`endif

    assign bus.hazir_o       = hazir_q;
    assign bus.crc_o         = crc_cikis_q;
    assign bus.crc_gecerli_o = crc_gecerli_q;
    assign bus.mesgul_o      = mesgul_q;

endmodule

// File: tb/tb_crc_motoru.sv
// -----------------------------------------------------------------------------
// tb_crc_motoru
// Three engine instances: CRC-16/CCITT-FALSE byte-wide, CRC-32 (reflected)
// byte-wide, and CRC-16 with 4-byte beats. Expected CRC values are standard
// check values for the named algorithms.
// -----------------------------------------------------------------------------
module tb_crc_motoru;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crc_motoru_if #(.CRC_W(16), .BYTES(1)) if16 ();
    crc_motoru_if #(.CRC_W(32), .BYTES(1)) if32 ();
    crc_motoru_if #(.CRC_W(16), .BYTES(4)) ifw ();

    crc_motoru u16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if16)
    );

    crc_motoru #(
        .CRC_W   (32),
        .POLY    (32'h04C11DB7),
        .INIT    (32'hFFFFFFFF),
        .XOR_OUT (32'hFFFFFFFF),
        .REFLECT (1'b1),
        .BYTES   (1)
    ) u32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if32)
    );

    crc_motoru #(
        .BYTES (4)
    ) uw (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifw)
    );

    int checks = 0;
    int errors = 0;
    int p16 = 0;
    int p32 = 0;
    int pw  = 0;

    always @(negedge clk) begin
        if (if16.crc_gecerli_o === 1'b1) p16++;
        if (if32.crc_gecerli_o === 1'b1) p32++;
        if (ifw.crc_gecerli_o === 1'b1)  pw++;
    end

    typedef struct packed {
        logic        sel32;
        logic [71:0] veri;
        logic [3:0]  uzun;
        logic [31:0] beklenen;
    } vek_t;

    vek_t tablo [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic put1(input logic sel32, input logic g, input logic [7:0] d,
                        input logic be, input logic s, input logic b);
        if (sel32) begin
            if32.gecerli_i = g; if32.veri_i = d; if32.bayt_gecerli_i = be;
            if32.son_i = s; if32.basla_i = b;
        end else begin
            if16.gecerli_i = g; if16.veri_i = d; if16.bayt_gecerli_i = be;
            if16.son_i = s; if16.basla_i = b;
        end
    endtask

    task automatic wait_hazir1(input logic sel32);
        int n;
        n = 0;
        while ((sel32 ? if32.hazir_o : if16.hazir_o) !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL hazir timeout sel32=%0d actual=0 required=1", sel32);
        end
    endtask

    task automatic wait_hazirw();
        int n;
        n = 0;
        while (ifw.hazir_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL hazir timeout wide actual=0 required=1");
        end
    endtask

    // Sends the first uzun characters of veri (first char most significant),
    // one byte per beat; son on the last beat if son_last. An empty string
    // sends a single beat with all enables low.
    task automatic send1(input logic sel32, input logic [71:0] veri, input int uzun,
                         input logic son_last, input logic basla_first);
        if (uzun == 0) begin
            wait_hazir1(sel32);
            put1(sel32, 1'b1, 8'h00, 1'b0, son_last, basla_first);
            @(posedge clk); #1;
            put1(sel32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < uzun; i++) begin
                wait_hazir1(sel32);
                put1(sel32, 1'b1, veri[8*(uzun-1-i) +: 8], 1'b1,
                     son_last && (i == uzun - 1), basla_first && (i == 0));
                @(posedge clk); #1;
                put1(sel32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic end1(input logic sel32, input logic [31:0] exp, input string nm, input int p0);
        wait_hazir1(sel32);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk({nm, " crc"}, sel32 ? if32.crc_o : {16'h0000, if16.crc_o}, exp);
        chk({nm, " pulses"}, (sel32 ? p32 : p16) - p0, 32'd1);
    endtask

    task automatic beatw(input logic [31:0] d, input logic [3:0] en, input logic s,
                         input int exp_low, input string nm);
        int n;
        wait_hazirw();
        ifw.gecerli_i = 1'b1; ifw.veri_i = d; ifw.bayt_gecerli_i = en; ifw.son_i = s;
        @(posedge clk); #1;
        ifw.gecerli_i = 1'b0; ifw.bayt_gecerli_i = 4'b0000; ifw.son_i = 1'b0;
        n = 0;
        while (ifw.hazir_o !== 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk({nm, " hazir low"}, n, exp_low);
    endtask

    task automatic endw(input logic [31:0] exp, input string nm, input int p0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk({nm, " crc"}, {16'h0000, ifw.crc_o}, exp);
        chk({nm, " pulses"}, pw - p0, 32'd1);
    endtask

    initial begin
        int p0;

        tablo[0] = '{1'b0, 72'("123456789"), 4'd9, 32'h000029B1};
        tablo[1] = '{1'b0, 72'("A"),         4'd1, 32'h0000B915};
        tablo[2] = '{1'b0, 72'h0,            4'd0, 32'h0000FFFF};
        tablo[3] = '{1'b1, 72'("123456789"), 4'd9, 32'hCBF43926};
        tablo[4] = '{1'b1, 72'("a"),         4'd1, 32'hE8B7BE43};
        tablo[5] = '{1'b1, 72'h0,            4'd0, 32'h00000000};

        put1(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        put1(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        ifw.gecerli_i = 1'b0; ifw.veri_i = '0; ifw.bayt_gecerli_i = '0;
        ifw.son_i = 1'b0; ifw.basla_i = 1'b0;
`ifdef CRC_DOGRULA_EN
        if16.beklenen_i = '0; if32.beklenen_i = '0; ifw.beklenen_i = '0;
`endif

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset hazir", if16.hazir_o, 32'd1);
        chk("reset mesgul", if16.mesgul_o, 32'd0);
        chk("reset crc", {16'h0000, if16.crc_o}, 32'h0);
        chk("reset crc_gecerli", if16.crc_gecerli_o, 32'd0);
        chk("reset crc32", if32.crc_o, 32'h0);

        for (int i = 0; i < 6; i++) begin
            p0 = tablo[i].sel32 ? p32 : p16;
            send1(tablo[i].sel32, tablo[i].veri, int'(tablo[i].uzun), 1'b1, 1'b0);
            end1(tablo[i].sel32, tablo[i].beklenen, $sformatf("tab%0d", i), p0);
        end

        // Abort with basla_i while a byte is in ISLE, then a clean frame.
        send1(1'b0, 72'("9"), 1, 1'b0, 1'b0);
        if16.basla_i = 1'b1;
        @(posedge clk); #1;
        if16.basla_i = 1'b0;
        chk("basla isle mesgul", if16.mesgul_o, 32'd1);
        chk("basla isle crc hold", {16'h0000, if16.crc_o}, 32'h0000FFFF);
        p0 = p16;
        send1(1'b0, 72'("123456789"), 9, 1'b1, 1'b0);
        end1(1'b0, 32'h000029B1, "basla isle", p0);

        // basla_i coinciding with the first beat of the new frame.
        send1(1'b0, 72'("55"), 2, 1'b0, 1'b0);
        p0 = p16;
        send1(1'b0, 72'("123456789"), 9, 1'b1, 1'b1);
        end1(1'b0, 32'h000029B1, "basla beat", p0);

`ifdef CRC_DOGRULA_EN
        if16.beklenen_i = 16'h29B1;
        p0 = p16;
        send1(1'b0, 72'("123456789"), 9, 1'b1, 1'b0);
        end1(1'b0, 32'h000029B1, "dogrula esit", p0);
        chk("hata esit", if16.hata_o, 32'd0);
        if16.beklenen_i = 16'h29B0;
        p0 = p16;
        send1(1'b0, 72'("123456789"), 9, 1'b1, 1'b0);
        end1(1'b0, 32'h000029B1, "dogrula farkli", p0);
        chk("hata farkli", if16.hata_o, 32'd1);
`endif

        // 4-byte beats.
        p0 = pw;
        beatw(32'h34333231, 4'b1111, 1'b0, 4, "w1234");
        beatw(32'h38373635, 4'b1111, 1'b0, 4, "w5678");
        beatw(32'h00000039, 4'b0001, 1'b1, 1, "w9");
        endw(32'h000029B1, "wide", p0);

        // Sparse enables and a zero-byte beat mid-frame.
        p0 = pw;
        beatw(32'hAA32BB31, 4'b0101, 1'b0, 2, "wsparse12");
        beatw(32'h353433CC, 4'b1110, 1'b0, 3, "wsparse345");
        beatw(32'h39383736, 4'b0000, 1'b0, 1, "wzero");
        beatw(32'h39383736, 4'b1111, 1'b1, 4, "w6789son");
        endw(32'h000029B1, "sparse", p0);

        repeat (5) @(posedge clk);
        #1;
        chk("wide crc hold", {16'h0000, ifw.crc_o}, 32'h000029B1);
        chk("wide idle mesgul", ifw.mesgul_o, 32'd0);

        // Wide empty frame.
        p0 = pw;
        beatw(32'h0, 4'b0000, 1'b1, 1, "wempty");
        endw(32'h0000FFFF, "wempty", p0);

        // Reset while a 4-byte beat is in ISLE.
        p0 = pw;
        beatw(32'h34333231, 4'b1111, 1'b0, 4, "wpre");
        wait_hazirw();
        ifw.gecerli_i = 1'b1; ifw.veri_i = 32'h38373635; ifw.bayt_gecerli_i = 4'b1111;
        @(posedge clk); #1;
        ifw.gecerli_i = 1'b0; ifw.bayt_gecerli_i = 4'b0000;
        chk("isle hazir", ifw.hazir_o, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst isle hazir", ifw.hazir_o, 32'd1);
        chk("rst isle crc", {16'h0000, ifw.crc_o}, 32'h0);
        chk("rst isle crc_gecerli", ifw.crc_gecerli_o, 32'd0);
        chk("rst isle mesgul", ifw.mesgul_o, 32'd0);
        chk("rst isle pulses", pw - p0, 32'd0);

        p0 = pw;
        beatw(32'h34333231, 4'b1111, 1'b0, 4, "wpost1234");
        beatw(32'h38373635, 4'b1111, 1'b0, 4, "wpost5678");
        beatw(32'h00000039, 4'b0001, 1'b1, 1, "wpost9");
        endw(32'h000029B1, "post reset", p0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_motoru.md
CRC_MOTORU -- requirements
Module: crc_motoru

Interface
REQ-001 SHALL have parameter CRC_W, default 16: CRC width; legal values 16 or 32.
REQ-002 SHALL have parameter POLY, default 16'h1021: generator polynomial, normal form, CRC_W bits.
REQ-003 SHALL have parameter INIT, default 16'hFFFF: register load value at frame start.
REQ-004 SHALL have parameter XOR_OUT, default 0: value XORed into the final result.
REQ-005 SHALL have parameter REFLECT, default 0: 1 = input bytes and final register bit-reversed.
REQ-006 SHALL have parameter BYTES, default 1: bytes per input beat; legal values 1, 2 or 4.
REQ-007 SHALL have port clk_i, input, 1 bit: single clock; all logic on the rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port basla_i, input, 1 bit: abort any frame, load INIT, open a new frame.
REQ-010 SHALL have port gecerli_i, input, 1 bit: input beat valid.
REQ-011 SHALL have port hazir_o, output, 1 bit: block accepts a beat this cycle.
REQ-012 SHALL have port veri_i, input, 8*BYTES bits: beat data; byte 0 in [7:0].
REQ-013 SHALL have port bayt_gecerli_i, input, BYTES bits: per-byte enable.
REQ-014 SHALL have port son_i, input, 1 bit: the beat is the last of the frame.
REQ-015 SHALL have port crc_o, output, CRC_W bits: final CRC of the last completed frame.
REQ-016 SHALL have port crc_gecerli_o, output, 1 bit: one-cycle pulse when crc_o updates.
REQ-017 SHALL have port mesgul_o, output, 1 bit: a frame is open or being processed.

Function
REQ-018 SHALL use states BOSTA (idle), BEKLE (frame open), ISLE (processing bytes) and SONUC (finalise); hazir_o = 1 only in BOSTA and BEKLE.
REQ-019 SHALL transfer a beat when gecerli_i and hazir_o are both high; a beat accepted in BOSTA implicitly opens a frame from INIT.
REQ-020 SHALL, on a transfer, latch veri_i, bayt_gecerli_i and son_i, then go to ISLE.
REQ-021 SHALL, in ISLE, process one enabled byte per cycle in ascending byte index; disabled bytes are skipped and take zero cycles.
REQ-022 SHALL, after the last enabled byte, go to SONUC if son_i was latched high, else to BEKLE.
REQ-023 SHALL treat a beat with all enables low as a zero-byte beat; with son_i high it goes straight to SONUC, yielding INIT^XOR_OUT for an empty frame.
REQ-024 SHALL compute each byte step MSB-first: register = (register << 8) ^ f(register[CRC_W-1:CRC_W-8] ^ byte), where f is the 8-shift division by POLY; with REFLECT=1 each byte is bit-reversed before the step.
REQ-025 SHALL, in SONUC, drive crc_o = (REFLECT ? bitrev(register) : register) ^ XOR_OUT and pulse crc_gecerli_o for exactly one cycle, then go to BOSTA.
REQ-026 SHALL hold crc_o stable until the next SONUC.
REQ-027 SHALL, on basla_i, load INIT and go to BEKLE in any state, with priority over all other transitions; if basla_i and a transfer coincide in BOSTA or BEKLE, the beat SHALL be processed from INIT.
REQ-028 SHALL drive mesgul_o = 1 in BEKLE, ISLE and SONUC.
REQ-029 SHALL, for a beat with n enabled bytes, take n cycles from the transfer to hazir_o re-asserting (minimum 1 cycle).

Reset
REQ-030 SHALL, on rst_i high at a clock edge (including mid-frame), enter BOSTA, load INIT and set crc_o = 0, crc_gecerli_o = 0 and mesgul_o = 0; hazir_o = 1 on the following cycle.

Configuration
REQ-031 SHALL, with CRC_DOGRULA_EN defined, add input beklenen_i (CRC_W bits) and output hata_o (1 bit); hata_o = (final CRC != beklenen_i), is valid with crc_gecerli_o and holds like crc_o.
REQ-032 SHALL, without CRC_DOGRULA_EN, omit beklenen_i, hata_o and all comparison logic.

Structure
REQ-033 SHALL place the state encoding and the legal CRC_W and BYTES values in shared package crc_sabitler_pkg.
REQ-034 SHALL implement the one-byte step as combinational sub-module crc_bayt_adim, parametrised by CRC_W and POLY, with no lookup ROM.

Verification
REQ-035 SHALL cover: default parameters, frame "123456789" one byte per beat, son_i on '9' -> crc_o = 0x29B1, one crc_gecerli_o pulse.
REQ-036 SHALL cover: CRC_W=32, POLY=0x04C11DB7, INIT=XOR_OUT=0xFFFFFFFF, REFLECT=1, frame "123456789" -> crc_o = 0xCBF43926.
REQ-037 SHALL cover: BYTES=4 with beats "1234"/1111, "5678"/1111, "9"/0001 plus son_i -> 0x29B1; hazir_o low 4, 4 and 1 cycles respectively.
REQ-038 SHALL cover: empty frame, gecerli_i with enables 0000 and son_i -> crc_o = 0xFFFF; and basla_i mid-frame followed by "123456789" -> 0x29B1.
REQ-039 SHALL cover: rst_i asserted in ISLE -> next cycle BOSTA, crc_o = 0, crc_gecerli_o = 0, hazir_o = 1.
REQ-040 SHALL cover, with CRC_DOGRULA_EN: beklenen_i = 0x29B1 -> hata_o = 0; beklenen_i = 0x29B0 -> hata_o = 1.
